// File: rtl/scan_mux.sv
// scan_mux: N-channel, W-bit registered selector.
//
// Two modes:
//   manual (mode=0): the channel is chosen by sel. An out-of-range sel keeps the
//                    last data/tag, drops out_valid and raises sel_err.
//   auto   (mode=1): round-robin over all channels, spending DWELL enabled
//                    cycles on each channel. sof marks the first sample of channel 0.
// All outputs are registered, so inputs sampled at edge k appear on the outputs
// after edge k. en=0 freezes every register.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   In        N_CH*W channel bus; channel c is In[c*W +: W]
//   sel       manual channel index
//   mode      0 = manual, 1 = auto-scan
//   en        clock enable
//   Out       selected data
//   out_ch    channel that Out was taken from
//   out_valid Out/out_ch are valid
//   sof       start of frame (auto-scan, channel 0, first dwell cycle)
//   sel_err   out-of-range manual sel was sampled
module scan_mux #(
  parameter int N_CH  = 10,
  parameter int W     = 1,
  parameter int SEL_W = 4,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] In,
  input  logic [SEL_W-1:0]  sel,
  input  logic              mode,
  input  logic              en,
  output logic [W-1:0]      Out,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  output logic              sof,
  output logic              sel_err
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(N_CH - 1);
  localparam logic [DW_W-1:0]  LAST_DWELL = DW_W'(DWELL - 1);

  // Mux written as a compare loop so indices >= N_CH never address past the bus.
  function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] bus,
                                        input logic [SEL_W-1:0]  idx);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (idx == SEL_W'(c)) r = bus[c*W +: W];
    end
    return r;
  endfunction

  logic [SEL_W-1:0] scan_ch;
  logic [DW_W-1:0]  dwell_cnt;
  logic             mode_q;

  // Scan position: on the mode-entry cycle (mode_q=0) the scan restarts at
  // channel 0, dwell 0, regardless of whatever stale position is stored.
  logic [SEL_W-1:0] ch_eff;
  logic [DW_W-1:0]  d_eff;
  logic             last_dwell;

  always_comb begin
    ch_eff     = mode_q ? scan_ch   : '0;
    d_eff      = mode_q ? dwell_cnt : '0;
    last_dwell = (d_eff == LAST_DWELL);
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      Out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sof       <= 1'b0;
      sel_err   <= 1'b0;
      scan_ch   <= '0;
      dwell_cnt <= '0;
      mode_q    <= 1'b0;
    end else if (en) begin
      mode_q <= mode;
      if (mode) begin
        Out       <= pick(In, ch_eff);
        out_ch    <= ch_eff;
        out_valid <= 1'b1;
        sel_err   <= 1'b0;
        sof       <= (ch_eff == '0) && (d_eff == '0);
        if (last_dwell) begin
          dwell_cnt <= '0;
          scan_ch   <= (ch_eff == LAST_CH) ? '0 : ch_eff + SEL_W'(1);
        end else begin
          dwell_cnt <= d_eff + DW_W'(1);
          scan_ch   <= ch_eff;
        end
      end else if (sel > LAST_CH) begin
        // Data and tag keep their last good values.
        out_valid <= 1'b0;
        sel_err   <= 1'b1;
        sof       <= 1'b0;
      end else begin
        Out       <= pick(In, sel);
        out_ch    <= sel;
        out_valid <= 1'b1;
        sel_err   <= 1'b0;
        sof       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;
  localparam int N_CH  = 10;
  localparam int W     = 8;
  localparam int SEL_W = 4;
  localparam int DWELL = 4;
  localparam int FRAME = N_CH * DWELL;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH*W-1:0] In;
  logic [SEL_W-1:0]  sel;
  logic              mode;
  logic              en;
  logic [W-1:0]      Out;
  logic [SEL_W-1:0]  out_ch;
  logic              out_valid;
  logic              sof;
  logic              sel_err;

  scan_mux #(.N_CH(N_CH), .W(W), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .In(In), .sel(sel), .mode(mode), .en(en),
    .Out(Out), .out_ch(out_ch), .out_valid(out_valid), .sof(sof), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the auto-scan is a position 0..FRAME-1 within a frame;
  // channel = pos / DWELL, sof = (pos == 0).
  logic [W-1:0] e_out;
  int           e_ch;
  logic         e_valid, e_sof, e_err;
  logic         m_mode_q;
  int           m_pos;

  task automatic model_step();
    int p;
    int c;
    if (rst) begin
      e_out = '0; e_ch = 0; e_valid = 0; e_sof = 0; e_err = 0;
      m_mode_q = 0; m_pos = 0;
    end else if (en) begin
      if (mode) begin
        p = m_mode_q ? m_pos : 0;
        c = p / DWELL;
        e_out = In[c*W +: W]; e_ch = c; e_valid = 1; e_err = 0; e_sof = (p == 0);
        m_pos = (p + 1) % FRAME;
      end else if (int'(sel) >= N_CH) begin
        e_valid = 0; e_err = 1; e_sof = 0;
      end else begin
        e_out = In[int'(sel)*W +: W]; e_ch = int'(sel);
        e_valid = 1; e_err = 0; e_sof = 0;
      end
      m_mode_q = mode;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("out",       32'(Out),       32'(e_out));
    chk("out_ch",    32'(out_ch),    32'(e_ch));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("sof",       32'(sof),       32'(e_sof));
    chk("sel_err",   32'(sel_err),   32'(e_err));
  endtask

  task automatic rand_in();
    In = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    int sof_cnt, sof_a, sof_b, gap;
    bit found;

    // Reset with random inputs
    rst = 1; en = 1; mode = 0; sel = 0; In = '0;
    for (int i = 0; i < 3; i++) begin
      rand_in(); sel = SEL_W'($urandom); mode = 1'($urandom); en = 1'($urandom);
      tick();
    end
    chk("rst_out", 32'(Out), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sel_err", 32'(sel_err), 0);

    // Release into manual sel=5 with only channel 5 set
    rst = 0; en = 1; mode = 0; sel = 5; In = '0; In[5*W] = 1'b1;
    tick();
    chk("rel_out", 32'(Out), 1);
    chk("rel_ch", 32'(out_ch), 5);
    chk("rel_valid", 32'(out_valid), 1);

    // Manual sweep including out-of-range selects
    for (int c = 0; c < N_CH; c++) In[c*W +: W] = W'(8'hA0 + c);
    for (int s = 0; s < 16; s++) begin
      sel = SEL_W'(s);
      tick();
    end
    chk("sweep_hold_out", 32'(Out), 32'h A9);
    chk("sweep_err", 32'(sel_err), 1);
    chk("sweep_valid", 32'(out_valid), 0);

    // Auto-scan from manual: sof only at cycles 0 and FRAME
    mode = 1; sof_cnt = 0; sof_a = -1; sof_b = -1;
    for (int k = 0; k <= FRAME; k++) begin
      if (k % 3 == 0) rand_in();
      tick();
      if (sof) begin
        if (sof_cnt == 0) sof_a = k; else sof_b = k;
        sof_cnt++;
      end
    end
    chk("auto_sof_cnt", 32'(sof_cnt), 2);
    chk("auto_sof_first", 32'(sof_a), 0);
    chk("auto_sof_second", 32'(sof_b), FRAME);

    // Enable freeze at channel 3, dwell 2 for 5 cycles: frame stretches to 45
    mode = 0; sel = 0; tick();
    mode = 1; gap = -1;
    for (int k = 0; k < 100; k++) begin
      en = !(k >= 14 && k < 19);
      tick();
      if (k == 13) chk("freeze_pre_ch", 32'(out_ch), 3);
      if (k == 18) chk("freeze_hold_ch", 32'(out_ch), 3);
      if (k > 0 && en && sof) begin gap = k; break; end
    end
    en = 1;
    chk("freeze_frame", 32'(gap), FRAME + 5);

    // Mode re-entry after leaving at channel 6
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (out_ch == 6) found = 1;
    end
    chk("reach_ch6", 32'(found), 1);
    mode = 0; sel = SEL_W'($urandom_range(0, N_CH - 1)); tick();
    mode = 1; tick();
    chk("reentry_ch", 32'(out_ch), 0);
    chk("reentry_sof", 32'(sof), 1);

    // Reset mid-scan at channel 7
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (out_ch == 7) found = 1;
    end
    chk("reach_ch7", 32'(found), 1);
    rst = 1; tick();
    chk("midrst_out", 32'(Out), 0);
    chk("midrst_ch", 32'(out_ch), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    rst = 0; tick();
    chk("postrst_ch", 32'(out_ch), 0);
    chk("postrst_sof", 32'(sof), 1);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      sel = SEL_W'($urandom);
      rand_in();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
